// File: rtl/puf_engine_pkg.sv
// Shared types and helpers for the ring-oscillator PUF engine.
// Holds the FSM state enum and the oscillator pair-select function.
package puf_engine_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_COUNT,
        S_COMPARE,
        S_DONE
    } state_t;

    // Widths for the default 16-oscillator, 3-vote build.
    localparam int unsigned DEF_N_RO  = 16;
    localparam int unsigned DEF_VOTES = 3;
    localparam int unsigned IDX_W     = $clog2(DEF_N_RO);
    localparam int unsigned VCNT_W    = $clog2(DEF_VOTES + 1);

    // Returns {a, b}: a in [31:16], b in [15:0].
    // b sits half the ring away from a, so they never collide.
    function automatic logic [31:0] pair_idx(
        input int unsigned c,
        input int unsigned i,
        input int unsigned n_ro
    );
        int unsigned a;
        int unsigned b;
        a = (c + i) % n_ro;
        b = (c + i + n_ro / 2) % n_ro;
        return {a[15:0], b[15:0]};
    endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// Synchronised rising-edge counter for one selected oscillator.
// The settle mask hides edges the mux switch could fake after a clear.
module ro_edge_counter
    import puf_engine_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ro,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [1:0] sync;
    logic       prev;
    logic [1:0] settle;
    logic       rise;

    assign rise = sync[1] & ~prev & settle[1];

    // Two-flop synchroniser plus delayed copy for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[0], ro};
            prev <= sync[1];
        end
    end

    // Block edges until the pipeline holds only the newly selected input.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            settle <= '0;
        end else if (clr) begin
            settle <= '0;
        end else begin
            settle <= {settle[0], 1'b1};
        end
    end

    // Saturating edge count, zeroed by clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && rise && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ro_puf_engine.sv
// Ring-oscillator PUF engine: per-bit pair race, majority-voted.
// PUF_UNSTABLE_MASK_EN builds the per-bit vote-disagreement flags.
module ro_puf_engine
    import puf_engine_pkg::*;
#(
    parameter int unsigned CHAL_BITS = 8,
    parameter int unsigned RESP_BITS = 8,
    parameter int unsigned N_RO      = 16,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned WINDOW    = 1024,
    parameter int unsigned VOTES     = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 start,
    input  logic [CHAL_BITS-1:0] challenge,
    input  logic [N_RO-1:0]      ro_osc,
    output logic                 busy,
    output logic                 done,
    output logic [RESP_BITS-1:0] response,
    output logic [RESP_BITS-1:0] unstable,
    input  logic                 orred,
    output logic                 done_sig
);

    localparam int unsigned IW = $clog2(N_RO);
    localparam int unsigned VW = $clog2(VOTES + 1);
    localparam int unsigned BW =
        (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam int unsigned WW = $clog2(WINDOW + 1);

    state_t               state;
    logic [IW-1:0]        chal;
    logic [BW-1:0]        bit_idx;
    logic [VW-1:0]        vote_idx;
    logic [VW-1:0]        acc;
    logic [VW-1:0]        acc_nx;
    logic [WW-1:0]        win;
    logic [RESP_BITS-1:0] stage;
    logic [RESP_BITS-1:0] stage_nx;
    logic [31:0]          pair;
    logic [IW-1:0]        sel_a;
    logic [IW-1:0]        sel_b;
    logic [CNT_W-1:0]     cnt_a;
    logic [CNT_W-1:0]     cnt_b;
    logic                 samp;
    logic                 bit_val;
    logic                 vote_end;
    logic                 run_end;

    assign pair  = pair_idx(32'(chal), 32'(bit_idx), N_RO);
    assign sel_a = IW'(pair[31:16]);
    assign sel_b = IW'(pair[15:0]);

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .clk     (clk),
        .reset_n (reset_n),
        .ro      (ro_osc[sel_a]),
        .clr     (state == S_CLEAR),
        .en      (state == S_COUNT),
        .count   (cnt_a)
    );

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .clk     (clk),
        .reset_n (reset_n),
        .ro      (ro_osc[sel_b]),
        .clr     (state == S_CLEAR),
        .en      (state == S_COUNT),
        .count   (cnt_b)
    );

    // Strict compare: ties, saturated or not, vote 0.
    assign samp     = cnt_a > cnt_b;
    assign acc_nx   = acc + VW'(samp);
    assign bit_val  = acc_nx > VW'(VOTES / 2);
    assign vote_end = (state == S_COMPARE) && enable &&
                      (vote_idx == VW'(VOTES - 1));
    assign run_end  = vote_end &&
                      (bit_idx == BW'(RESP_BITS - 1));
    assign done_sig = orred | done;

    // Staging image with the current bit's majority merged in.
    always_comb begin
        stage_nx = stage;
        for (int k = 0; k < RESP_BITS; k++) begin
            if (bit_idx == BW'(k)) stage_nx[k] = bit_val;
        end
    end

    // Main sequencer: clear, count window, compare, vote, advance bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            chal     <= '0;
            bit_idx  <= '0;
            vote_idx <= '0;
            acc      <= '0;
            win      <= '0;
            stage    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            response <= '0;
        end else begin
            done <= 1'b0;
            if ((state != S_IDLE) && !enable) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start && enable) begin
                            chal     <= IW'(challenge);
                            bit_idx  <= '0;
                            vote_idx <= '0;
                            acc      <= '0;
                            busy     <= 1'b1;
                            state    <= S_CLEAR;
                        end
                    end
                    S_CLEAR: begin
                        win   <= '0;
                        state <= S_COUNT;
                    end
                    S_COUNT: begin
                        win <= win + WW'(1);
                        if (win == WW'(WINDOW - 1)) begin
                            state <= S_COMPARE;
                        end
                    end
                    S_COMPARE: begin
                        if (!vote_end) begin
                            vote_idx <= vote_idx + VW'(1);
                            acc      <= acc_nx;
                            state    <= S_CLEAR;
                        end else begin
                            stage    <= stage_nx;
                            vote_idx <= '0;
                            acc      <= '0;
                            if (run_end) begin
                                response <= stage_nx;
                                busy     <= 1'b0;
                                done     <= 1'b1;
                                state    <= S_DONE;
                            end else begin
                                bit_idx <= bit_idx + BW'(1);
                                state   <= S_CLEAR;
                            end
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef PUF_UNSTABLE_MASK_EN
    logic                 bit_unst;
    logic [RESP_BITS-1:0] stage_u;
    logic [RESP_BITS-1:0] stage_u_nx;

    assign bit_unst = (acc_nx != '0) && (acc_nx != VW'(VOTES));

    // Staging flags with the current bit's disagreement merged in.
    always_comb begin
        stage_u_nx = stage_u;
        for (int k = 0; k < RESP_BITS; k++) begin
            if (bit_idx == BW'(k)) stage_u_nx[k] = bit_unst;
        end
    end

    // Record split votes per bit and publish them with the response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_u  <= '0;
            unstable <= '0;
        end else begin
            if (vote_end) stage_u <= stage_u_nx;
            if (run_end) unstable <= stage_u_nx;
        end
    end
`else
    assign unstable = '0;
`endif

endmodule

// File: tb/tb_ro_puf_engine.sv
// Directed bench for ro_puf_engine with a divided-clock oscillator model.
// A second small-counter instance exercises counter saturation.
module tb_ro_puf_engine;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        start;
    logic [7:0]  challenge;
    logic [15:0] ro_osc = '0;
    logic        busy;
    logic        done;
    logic [7:0]  response;
    logic [7:0]  unstable;
    logic        orred;
    logic        done_sig;

    logic        en2;
    logic        start2;
    logic [7:0]  ch2;
    logic        busy2;
    logic        done2;
    logic [0:0]  resp2;
    logic [0:0]  unst2;
    logic        done_sig2;

    int n_chk  = 0;
    int n_fail = 0;
    int tick   = 0;
    int cur_lat = 0;
    int fast_lo = 1;
    int fast_hi = 0;
    bit tie_mode = 1'b0;

`ifdef PUF_UNSTABLE_MASK_EN
    localparam logic [7:0] SPLIT_UNST = 8'h02;
`else
    localparam logic [7:0] SPLIT_UNST = 8'h00;
`endif

    always #5 clk = ~clk;

    ro_puf_engine #(
        .WINDOW (64),
        .VOTES  (3)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .start     (start),
        .challenge (challenge),
        .ro_osc    (ro_osc),
        .busy      (busy),
        .done      (done),
        .response  (response),
        .unstable  (unstable),
        .orred     (orred),
        .done_sig  (done_sig)
    );

    ro_puf_engine #(
        .RESP_BITS (1),
        .CNT_W     (4),
        .WINDOW    (600),
        .VOTES     (1)
    ) u_sat (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (en2),
        .start     (start2),
        .challenge (ch2),
        .ro_osc    (ro_osc),
        .busy      (busy2),
        .done      (done2),
        .response  (resp2),
        .unstable  (unst2),
        .orred     (1'b0),
        .done_sig  (done_sig2)
    );

    // ro_osc[k] toggles every k+2 cycles, with tie and burst overrides.
    always @(negedge clk) begin
        logic [15:0] q;
        tick = tick + 1;
        for (int k = 0; k < 16; k++) begin
            q[k] = ((tick / (k + 2)) % 2) == 1;
        end
        if (tie_mode) q[8] = q[0];
        if (cur_lat >= fast_lo && cur_lat <= fast_hi) q[9] = tick[0];
        ro_osc = q;
    end

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic run(
        input  bit         two,
        input  logic [7:0] ch,
        output int         lat,
        output bit         bok,
        output bit         dsig,
        output bit         bdone
    );
        @(negedge clk);
        if (two) begin
            ch2 = ch;
            start2 = 1'b1;
        end else begin
            challenge = ch;
            start = 1'b1;
        end
        @(posedge clk);
        #1;
        start  = 1'b0;
        start2 = 1'b0;
        lat   = 0;
        bok   = 1'b1;
        dsig  = 1'b0;
        bdone = 1'b1;
        while (lat < 4000) begin
            @(negedge clk);
            lat++;
            cur_lat = lat;
            if (two ? done2 : done) begin
                dsig  = two ? done_sig2 : done_sig;
                bdone = two ? busy2 : busy;
                break;
            end
            if (!(two ? busy2 : busy)) bok = 1'b0;
        end
        cur_lat = 0;
    endtask

    initial begin
        int lat;
        int pulses;
        bit bok;
        bit dsig;
        bit bdone;

        reset_n = 1'b0;
        enable = 1'b1;
        start = 1'b0;
        challenge = '0;
        orred = 1'b0;
        en2 = 1'b1;
        start2 = 1'b0;
        ch2 = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_resp", response, 0);
        check("rst_unst", unstable, 0);
        check("rst_dsig", done_sig, 0);
        reset_n = 1'b1;

        run(1'b0, 8'h00, lat, bok, dsig, bdone);
        check("lat_00", lat, 1585);
        check("busy_run", bok, 1);
        check("busy_at_done", bdone, 0);
        check("dsig_at_done", dsig, 1);
        check("resp_00", response, 8'hFF);
        check("unst_00", unstable, 8'h00);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("resp_held", response, 8'hFF);

        run(1'b0, 8'h08, lat, bok, dsig, bdone);
        check("resp_08", response, 8'h00);
        run(1'b0, 8'h04, lat, bok, dsig, bdone);
        check("resp_04_wrap", response, 8'h0F);

        // Abort during bit 3, vote 0 counting window.
        @(negedge clk);
        challenge = 8'h00;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (619) @(negedge clk);
        check("abort_busy_pre", busy, 1);
        enable = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_dis_ign", busy, 0);
        pulses = 0;
        for (int n = 0; n < 1700; n++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("abort_no_done", pulses, 0);
        check("abort_resp", response, 8'h0F);
        enable = 1'b1;

        run(1'b0, 8'h07, lat, bok, dsig, bdone);
        check("lat_07", lat, 1585);
        check("resp_07", response, 8'h01);
        run(1'b0, 8'h14, lat, bok, dsig, bdone);
        check("resp_14_hi", response, 8'h0F);

        tie_mode = 1'b1;
        run(1'b0, 8'h00, lat, bok, dsig, bdone);
        tie_mode = 1'b0;
        check("resp_tie", response, 8'hFE);
        check("unst_tie", unstable, 8'h00);

        // Reset mid-run clears outputs at once.
        @(negedge clk);
        challenge = 8'h00;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (300) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_resp", response, 0);
        check("mid_rst_dsig", done_sig, 0);
        orred = 1'b1;
        #1;
        check("orred_rst", done_sig, 1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("orred_idle", done_sig, 1);
        orred = 1'b0;
        #1;
        check("orred_off", done_sig, 0);

        // Bit 1 vote 0 sees a fast ro_osc[9] (normally the slow side).
        fast_lo = 199;
        fast_hi = 263;
        run(1'b0, 8'h08, lat, bok, dsig, bdone);
        fast_lo = 1;
        fast_hi = 0;
        check("resp_split", response, 8'h00);
        check("unst_split", unstable, SPLIT_UNST);

        run(1'b1, 8'h07, lat, bok, dsig, bdone);
        check("lat_sat", lat, 603);
        check("resp_sat", resp2, 0);
        run(1'b1, 8'h00, lat, bok, dsig, bdone);
        check("resp_sat_0", resp2, 0);
        check("unst_sat", unst2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
